// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage controller for the five-stage MIPS pipeline. Takes the EX/MEM
//   register outputs, performs data-memory loads/stores over a req/ack bus,
//   stalls upstream stages while an access is pending, loads the MEM/WB
//   register, and drives the fetch-stage PC select.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   *_exmem                      EX/MEM control bits, destination, ALU result, store data
//   dmem_req/we/addr/wdata       data-memory request (held until ack or abort)
//   dmem_ack, dmem_rdata         single-cycle completion pulse and load data
//   stall                        combinational; holds upstream stages incl. EX/MEM
//   pc_src                       combinational; jump | (branch & zero)
//   *_memwb                      MEM/WB pipeline register outputs
//   bus_error                    sticky error flag (misalignment, r+w, timeout)
module mem_access_unit #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_exmem,
  input  logic        mem_write_exmem,
  input  logic        mem_to_reg_exmem,
  input  logic        reg_write_exmem,
  input  logic        jump_exmem,
  input  logic        branch_exmem,
  input  logic        zero_exmem,
  input  logic [4:0]  writebackreg_exmem,
  input  logic [31:0] alu_result_exmem,
  input  logic [31:0] rt_data_exmem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pc_src,
  output logic        reg_write_memwb,
  output logic        mem_to_reg_memwb,
  output logic [4:0]  writebackreg_memwb,
  output logic [31:0] alu_result_memwb,
  output logic [31:0] read_data_memwb,
  output logic        bus_error
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]        state;
  logic [WCNT_W-1:0] wcnt;

  logic acc;
  logic err;
  logic ack_done;
  logic timeout;
  logic wb_pass;

  always_comb begin
    acc      = mem_read_exmem | mem_write_exmem;
    err      = acc & ((alu_result_exmem[1:0] != 2'b00) |
                      (mem_read_exmem & mem_write_exmem));
    ack_done = (state == WAIT) & dmem_ack;
    // An ack in the last WAIT cycle takes priority over the abort.
    timeout  = (state == WAIT) & ~dmem_ack & (wcnt == WCNT_LAST);
    // MEM/WB takes the real instruction only for non-memory ops in IDLE and
    // on a completed access; every other cycle it receives a bubble.
    wb_pass  = ((state == IDLE) & ~acc) | ack_done;
    if (state == IDLE) stall = acc & ~err;
    else               stall = ~dmem_ack & ~timeout;
  end

  assign pc_src = jump_exmem | (branch_exmem & zero_exmem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      wcnt               <= '0;
      dmem_req           <= 1'b0;
      dmem_we            <= 1'b0;
      dmem_addr          <= '0;
      dmem_wdata         <= '0;
      bus_error          <= 1'b0;
      reg_write_memwb    <= 1'b0;
      mem_to_reg_memwb   <= 1'b0;
      writebackreg_memwb <= '0;
      alu_result_memwb   <= '0;
      read_data_memwb    <= '0;
    end else begin
      if (wb_pass) begin
        reg_write_memwb    <= reg_write_exmem;
        mem_to_reg_memwb   <= mem_to_reg_exmem;
        writebackreg_memwb <= writebackreg_exmem;
        alu_result_memwb   <= alu_result_exmem;
        read_data_memwb    <= (ack_done & mem_read_exmem) ? dmem_rdata : '0;
      end else begin
        reg_write_memwb    <= 1'b0;
        mem_to_reg_memwb   <= 1'b0;
        writebackreg_memwb <= '0;
        alu_result_memwb   <= '0;
        read_data_memwb    <= '0;
      end

      case (state)
        IDLE: begin
          if (err) begin
            bus_error <= 1'b1;
          end else if (acc) begin
            state      <= WAIT;
            wcnt       <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_exmem;
            dmem_addr  <= alu_result_exmem;
            dmem_wdata <= rt_data_exmem;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
          end else if (timeout) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            bus_error <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage controller for the five-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs and performs data-memory loads and stores over a req/ack bus. While an access is pending it stalls the upstream pipeline. When the access completes it loads the MEM/WB pipeline register. It also produces the branch/jump PC-select signal for the fetch stage.

## Interface
- MEM_TIMEOUT, 15, maximum number of WAIT cycles without dmem_ack before the access is aborted (1..255).
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- mem_read_exmem, mem_write_exmem, mem_to_reg_exmem, reg_write_exmem  in  1 each  EX/MEM control bits
- jump_exmem, branch_exmem, zero_exmem  in  1 each  EX/MEM control-flow bits
- writebackreg_exmem  in  5  destination register number
- alu_result_exmem  in  32  effective address, or ALU result
- rt_data_exmem  in  32  store data
- dmem_req  out  1  bus request, held until ack or abort
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete, single-cycle pulse
- dmem_rdata  in  32  load data, valid when dmem_ack=1
- stall  out  1  combinational; 1 = upstream stages, including EX/MEM, hold their contents
- pc_src  out  1  combinational; jump_exmem | (branch_exmem & zero_exmem)
- reg_write_memwb, mem_to_reg_memwb  out  1 each  MEM/WB control bits
- writebackreg_memwb  out  5  MEM/WB destination register
- alu_result_memwb  out  32  MEM/WB ALU result
- read_data_memwb  out  32  MEM/WB load data
- bus_error  out  1  sticky error flag; cleared only by rst

## Operation
- Access request: acc = mem_read_exmem | mem_write_exmem.
- Error condition, evaluated in IDLE: err = acc & (alu_result_exmem[1:0] != 0 or mem_read_exmem & mem_write_exmem).
- FSM has two states, IDLE and WAIT. A wait counter wcnt has width ceil(log2(MEM_TIMEOUT+1)).
- IDLE, acc=0: pass-through.
  - At the edge, MEM/WB loads the EX/MEM fields.
  - read_data_memwb <= 0.
  - stall=0.
- IDLE, err=1: no bus activity, stall=0.
  - bus_error <= 1.
  - MEM/WB loads a bubble: reg_write_memwb=0, mem_to_reg_memwb=0, all other MEM/WB fields 0.
  - The instruction is dropped.
- IDLE, acc=1 and err=0: stall=1 and the FSM goes to WAIT.
  - Registered at the same edge: dmem_req <= 1, dmem_we <= mem_write_exmem, dmem_addr <= alu_result_exmem, dmem_wdata <= rt_data_exmem, wcnt <= 0.
  - MEM/WB loads a bubble.
- WAIT, dmem_ack=0: stall=1, wcnt increments, MEM/WB loads a bubble.
- WAIT, dmem_ack=1: stall=0, and at the edge:
  - MEM/WB loads the EX/MEM fields.
  - read_data_memwb <= dmem_rdata for a load, 0 for a store.
  - dmem_req <= 0, FSM -> IDLE.
- WAIT, dmem_ack=0 and wcnt == MEM_TIMEOUT-1: abort.
  - stall=0, dmem_req <= 0, bus_error <= 1.
  - MEM/WB loads a bubble, FSM -> IDLE.
- An ack in the timeout cycle wins: the access completes normally and there is no error.
- dmem_ack seen in IDLE is ignored.
- pc_src is purely combinational from the EX/MEM inputs and is independent of the FSM.

## Timing
- Reset: every registered output is 0, FSM=IDLE, wcnt=0. dmem_req drops immediately, and no MEM/WB write occurs for an interrupted access.
- Non-memory instruction: MEM/WB is valid 1 cycle after the instruction is presented on EX/MEM.
- Memory access with ack in the Nth WAIT cycle (N≥1):
  - stall is high for N cycles: the IDLE cycle plus the first N-1 WAIT cycles. It is low in the ack cycle.
  - MEM/WB is valid at the edge ending the ack cycle.
  - The instruction therefore occupies the MEM stage for N+1 cycles.
- Abort: stall is high for MEM_TIMEOUT cycles. bus_error rises at the edge ending the last WAIT cycle.
- Back-to-back accesses: after an ack the FSM is IDLE with the next EX/MEM contents. A following access raises stall in that same cycle, with no dead cycle.
- Bus rule: dmem_addr, dmem_we and dmem_wdata are stable while dmem_req=1.

## Test plan
- Reset during WAIT (ack never given): rst asserted mid-access -> dmem_req=0 asynchronously, stall=0, all MEM/WB outputs 0, bus_error=0; after release an ALU op (reg_write=1, rd=9, result 0x1) -> reg_write_memwb=1, writebackreg_memwb=9, alu_result_memwb=0x1 one cycle later.
- Load addr 0x100, ack on the 3rd WAIT cycle with rdata 0xDEADBEEF -> stall high for 3 cycles; read_data_memwb=0xDEADBEEF, mem_to_reg_memwb=1, bubbles before it.
- Store addr 0x40, data 0x12345678, ack on the 1st WAIT cycle -> dmem_we=1, dmem_wdata=0x12345678, stall for 1 cycle, read_data_memwb=0.
- Misaligned load addr 0x102 -> no dmem_req, bus_error=1, bubble in MEM/WB; the next instruction proceeds. Also mem_read=mem_write=1 -> same response.
- Timeout with MEM_TIMEOUT=4, no ack -> stall for 4 cycles, dmem_req drops, bus_error=1, bubble. Repeat with ack in the 4th WAIT cycle -> normal completion, bus_error stays 0.
- branch=1, zero=1 -> pc_src=1 in the same cycle; branch=1, zero=0, jump=0 -> pc_src=0; jump=1 -> pc_src=1.
